// File: rtl/lamp_pkg.sv
// Shared helpers for the lamp driver: width calculation and saturating
// level arithmetic done at full integer width so no intermediate wrap occurs.
package lamp_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max_v);
    return ((a + b) > max_v) ? max_v : (a + b);
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/lamp_channel.sv
// One lamp: saturating brightness integrator plus PWM compare and output flop.
module lamp_channel
  import lamp_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned RISE = 32,
  parameter int unsigned FALL = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stb,
  input  logic            enable,
  input  logic            in_i,
  input  logic [BITS-1:0] pwm_cnt,
  output logic [BITS-1:0] level_o,
  output logic            out_o
);

  localparam int unsigned MAX = (2 ** BITS) - 1;

  logic [BITS-1:0] level_q, level_d;
  logic            out_q, out_d;

  always_comb begin
    level_d = level_q;
    if (stb) begin
      if (in_i) level_d = BITS'(sat_add(32'(level_q), RISE, MAX));
      else      level_d = BITS'(sat_sub(32'(level_q), FALL));
    end
    // Compare uses the pre-update level; MAX forces a solid-on output.
    out_d = enable & ((level_q > pwm_cnt) | (level_q == BITS'(MAX)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      out_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      out_q   <= out_d;
    end
  end

  assign level_o = level_q;
  assign out_o   = out_q;

endmodule

// File: rtl/lamp_driver.sv
// Panel lamp driver: shared prescaler and PWM counter feeding LAMPS
// independent persistence-emulating channels, with a level observation mux.
module lamp_driver
  import lamp_pkg::*;
#(
  parameter int unsigned LAMPS       = 12,
  parameter int unsigned BITS        = 8,
  parameter int unsigned TICK_CYCLES = 50000,
  parameter int unsigned RISE        = 32,
  parameter int unsigned FALL        = 16,
  localparam int unsigned SelW       = (clog2(LAMPS) > 0) ? clog2(LAMPS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LAMPS-1:0] in,
  input  logic            enable,
  input  logic [SelW-1:0] sel,
  output logic [BITS-1:0] level,
  output logic            tick,
  output logic [LAMPS-1:0] out
);

  localparam int unsigned CntW = (clog2(TICK_CYCLES) > 0) ? clog2(TICK_CYCLES) : 1;

  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic            tick_q, tick_d;
  logic            stb;
  logic [BITS-1:0] levels [LAMPS];

  always_comb begin
    stb        = (tick_cnt_q == CntW'(TICK_CYCLES - 1));
    tick_cnt_d = stb ? '0 : tick_cnt_q + CntW'(1);
    pwm_cnt_d  = pwm_cnt_q + BITS'(1);
    tick_d     = stb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < LAMPS; i++) begin : g_lamp
    lamp_channel #(
      .BITS(BITS),
      .RISE(RISE),
      .FALL(FALL)
    ) u_channel (
      .clk    (clk),
      .rst    (rst),
      .stb    (stb),
      .enable (enable),
      .in_i   (in[i]),
      .pwm_cnt(pwm_cnt_q),
      .level_o(levels[i]),
      .out_o  (out[i])
    );
  end

  // Out-of-range selects read as zero.
  always_comb begin
    level = '0;
    for (int i = 0; i < LAMPS; i++) begin
      if (sel == SelW'(i)) level = levels[i];
    end
  end

endmodule

// File: tb/tb_lamp_driver.sv
// Bench for lamp_driver: table vectors, hand sequences and a randomized run
// checked every cycle against an arithmetic model of ramp, decay and duty.
module tb_lamp_driver;

  localparam int unsigned TC = 4, RI = 4, FA = 2, MAXV = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_v = '0;
  logic       en = 1'b1;
  logic [1:0] sel = '0;
  logic [3:0] level;
  logic       tick;
  logic [2:0] out;

  logic [2:0] in64 = '0;
  logic       en64 = 1'b1;
  logic [1:0] sel64 = 2'd1;
  logic [3:0] level64;
  logic       tick64;
  logic [2:0] out64;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  bit mon_en = 1'b1;

  always #5 clk = ~clk;

  lamp_driver #(.LAMPS(3), .BITS(4), .TICK_CYCLES(TC), .RISE(RI), .FALL(FA)) dut (
    .clk(clk), .rst(rst), .in(in_v), .enable(en), .sel(sel),
    .level(level), .tick(tick), .out(out)
  );

  lamp_driver #(.LAMPS(3), .BITS(4), .TICK_CYCLES(64), .RISE(RI), .FALL(FA)) dut64 (
    .clk(clk), .rst(rst), .in(in64), .enable(en64), .sel(sel64),
    .level(level64), .tick(tick64), .out(out64)
  );

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic wait_tick(input bit big, input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = 0;
      @(negedge clk);
      while ((big ? tick64 : tick) !== 1'b1 && c < 100) begin
        @(negedge clk);
        c++;
      end
      if ((big ? tick64 : tick) !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout got 0 want 1 at %0t", $time);
      end
    end
  endtask

  function automatic int count_to_tick();
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  // Reference model: time since reset drives both the tick phase and pwm phase.
  int         m_lvl [3];
  logic [2:0] m_out;
  logic       m_tick;
  int         m_cyc;

  always @(posedge clk) begin
    int pwm;
    bit stb_m;
    int want_lvl;
    if (rst) begin
      for (int i = 0; i < 3; i++) m_lvl[i] = 0;
      m_out  = '0;
      m_tick = 1'b0;
      m_cyc  = 0;
    end else begin
      pwm   = m_cyc % 16;
      stb_m = (m_cyc % TC) == TC - 1;
      for (int i = 0; i < 3; i++)
        m_out[i] = en && (m_lvl[i] > pwm || m_lvl[i] == MAXV);
      m_tick = stb_m;
      if (stb_m) begin
        for (int i = 0; i < 3; i++) begin
          if (in_v[i]) m_lvl[i] = (m_lvl[i] + RI > MAXV) ? MAXV : m_lvl[i] + RI;
          else         m_lvl[i] = (m_lvl[i] < FA) ? 0 : m_lvl[i] - FA;
        end
      end
      m_cyc++;
    end
    #2;
    if (mon_en) begin
      want_lvl = (sel < 3) ? m_lvl[sel] : 0;
      chk("mon_out", int'(out), int'(m_out));
      chk("mon_tick", int'(tick), int'(m_tick));
      chk("mon_level", int'(level), want_lvl);
    end
  end

  typedef struct {
    logic [2:0] in;
    logic [1:0] sel;
    int         ticks;
    int         lvl;
    bit         hold;
    logic       obit;
  } vec_t;

  vec_t vecs [22];

  initial begin
    int c, bad, highs;
    vecs[0]  = '{3'b001, 2'd0, 1, 4,  1'b0, 1'b0};
    vecs[1]  = '{3'b001, 2'd0, 1, 8,  1'b0, 1'b0};
    vecs[2]  = '{3'b001, 2'd0, 1, 12, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 2'd0, 1, 15, 1'b1, 1'b1};
    vecs[4]  = '{3'b001, 2'd0, 1, 15, 1'b0, 1'b0};
    vecs[5]  = '{3'b000, 2'd0, 1, 13, 1'b0, 1'b0};
    vecs[6]  = '{3'b000, 2'd0, 1, 11, 1'b0, 1'b0};
    vecs[7]  = '{3'b000, 2'd0, 1, 9,  1'b0, 1'b0};
    vecs[8]  = '{3'b000, 2'd0, 1, 7,  1'b0, 1'b0};
    vecs[9]  = '{3'b000, 2'd0, 1, 5,  1'b0, 1'b0};
    vecs[10] = '{3'b000, 2'd0, 1, 3,  1'b0, 1'b0};
    vecs[11] = '{3'b000, 2'd0, 1, 1,  1'b0, 1'b0};
    vecs[12] = '{3'b000, 2'd0, 1, 0,  1'b1, 1'b0};
    vecs[13] = '{3'b000, 2'd0, 1, 0,  1'b0, 1'b0};
    vecs[14] = '{3'b101, 2'd0, 3, 12, 1'b0, 1'b0};
    vecs[15] = '{3'b101, 2'd2, 0, 12, 1'b0, 1'b0};
    vecs[16] = '{3'b101, 2'd1, 0, 0,  1'b0, 1'b0};
    vecs[17] = '{3'b101, 2'd3, 0, 0,  1'b0, 1'b0};
    vecs[18] = '{3'b000, 2'd2, 1, 10, 1'b0, 1'b0};
    vecs[19] = '{3'b010, 2'd1, 1, 4,  1'b0, 1'b0};
    vecs[20] = '{3'b010, 2'd0, 0, 8,  1'b0, 1'b0};
    vecs[21] = '{3'b010, 2'd3, 0, 0,  1'b0, 1'b0};

    // Reset held three cycles, then tick latency and period.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out", int'(out), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_tick", int'(tick), 0);
    for (int k = 0; k < 2; k++) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (tick !== 1'b1 && c < 20);
      chk(k == 0 ? "first_tick_lat" : "tick_period", c, 4);
    end

    // Rise, saturation, decay, independence and out-of-range select.
    for (int i = 0; i < 22; i++) begin
      in_v = vecs[i].in;
      sel  = vecs[i].sel;
      if (vecs[i].ticks == 0) @(negedge clk);
      else wait_tick(1'b0, vecs[i].ticks);
      chk($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
      if (vecs[i].hold) begin
        bad = 0;
        repeat (16) begin
          @(negedge clk);
          if (out[0] !== vecs[i].obit) bad++;
        end
        chk($sformatf("vec%0d_hold_out", i), bad, 0);
      end
    end

    // Reset mid-ramp.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_v = 3'b100;
    sel = 2'd2;
    wait_tick(1'b0, 2);
    chk("mid_pre_level", int'(level), 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_out", int'(out), 0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (tick !== 1'b1 && c < 20);
    chk("mid_rst_tick_lat", c, 4);

    // Duty cycle on the slow-tick instance.
    in_v = 3'b000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in64 = 3'b010;
    sel64 = 2'd1;
    en64 = 1'b1;
    wait_tick(1'b1, 2);
    chk("duty_ramp_level", int'(level64), 8);
    in64 = 3'b000;
    wait_tick(1'b1, 1);
    chk("duty_level", int'(level64), 6);
    bad = 0;
    highs = 0;
    repeat (48) begin
      @(negedge clk);
      if (out64[1] !== (((ecnt - 1) % 16) < 6)) bad++;
      if (out64[1] === 1'b1) highs++;
    end
    chk("duty_align", bad, 0);
    chk("duty_highs", highs, 18);
    en64 = 1'b0;
    @(negedge clk);
    chk("blank_out", int'(out64), 0);
    wait_tick(1'b1, 1);
    chk("blank_level", int'(level64), 4);
    chk("blank_out_tick", int'(out64), 0);
    en64 = 1'b1;
    bad = 0;
    highs = 0;
    repeat (16) begin
      @(negedge clk);
      if (out64[1] !== (((ecnt - 1) % 16) < 4)) bad++;
      if (out64[1] === 1'b1) highs++;
    end
    chk("resume_align", bad, 0);
    chk("resume_highs", highs, 4);

    // Randomized run; the model compares every cycle.
    repeat (200) begin
      in_v = 3'($urandom);
      en   = ($urandom % 4) != 0;
      sel  = 2'($urandom);
      if ($urandom % 40 == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
